// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, 2-flop row synchroniser, frame capture
// and a debouncing press/release FSM producing a one-hot key code.
//
// state   | meaning
// IDLE    | no key accepted; waiting for a single-key frame
// CONFIRM | candidate seen; counting identical frames toward acceptance
// HELD    | key accepted; key_onehot = cand
// RELEASE | zero frames seen while held; counting toward release
module hex_keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] key_onehot,
    output logic        key_valid,
    output logic        multi_err
);

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    logic [7:0]  div_cnt;
    logic [1:0]  col_idx;
    logic        sample_en;
    logic [11:0] frame_acc;
    logic [15:0] frame;
    logic        frame_rdy;
    logic        frame_zero;
    logic        frame_single;

    state_t      state, state_nxt;
    logic [15:0] cand, cand_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        valid_nxt;
    logic        merr_nxt;
    logic [15:0] onehot_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign sample_en = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            col_idx <= 2'd0;
        end else if (sample_en) begin
            div_cnt <= 8'd0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    always_comb begin
        col = ~(4'b0001 << col_idx);
    end

    // Every column overwrites its own nibble each frame, so no explicit clear is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_acc <= 12'd0;
            frame     <= 16'd0;
            frame_rdy <= 1'b0;
        end else begin
            frame_rdy <= 1'b0;
            if (sample_en) begin
                case (col_idx)
                    2'd0: frame_acc[3:0]  <= ~row_sync;
                    2'd1: frame_acc[7:4]  <= ~row_sync;
                    2'd2: frame_acc[11:8] <= ~row_sync;
                    default: begin
                        frame     <= {~row_sync, frame_acc};
                        frame_rdy <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign frame_zero   = (frame == 16'd0);
    assign frame_single = !frame_zero && ((frame & (frame - 16'd1)) == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cand       <= 16'd0;
            cnt        <= 4'd0;
            key_onehot <= 16'd0;
            key_valid  <= 1'b0;
            multi_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            key_onehot <= onehot_nxt;
            key_valid  <= valid_nxt;
            multi_err  <= merr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        valid_nxt = 1'b0;
        merr_nxt  = 1'b0;
        if (frame_rdy) begin
            case (state)
                IDLE: begin
                    if (frame_single) begin
                        cand_nxt = frame;
                        if (DEBOUNCE == 1) begin
                            state_nxt = HELD;
                            cnt_nxt   = 4'd0;
                            valid_nxt = 1'b1;
                        end else begin
                            state_nxt = CONFIRM;
                            cnt_nxt   = 4'd1;
                        end
                    end else if (!frame_zero) begin
                        merr_nxt = 1'b1;
                    end
                end
                CONFIRM: begin
                    if (frame == cand) begin
                        if (cnt == DEB_LAST) begin
                            state_nxt = HELD;
                            cnt_nxt   = 4'd0;
                            valid_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 4'd1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        cand_nxt  = 16'd0;
                        cnt_nxt   = 4'd0;
                    end
                end
                HELD: begin
                    // Rollover is ignored: only an all-zero frame starts a release.
                    if (frame_zero) begin
                        if (DEBOUNCE == 1) begin
                            state_nxt = IDLE;
                            cand_nxt  = 16'd0;
                            cnt_nxt   = 4'd0;
                        end else begin
                            state_nxt = RELEASE;
                            cnt_nxt   = 4'd1;
                        end
                    end
                end
                default: begin
                    if (frame_zero) begin
                        if (cnt == DEB_LAST) begin
                            state_nxt = IDLE;
                            cand_nxt  = 16'd0;
                            cnt_nxt   = 4'd0;
                        end else begin
                            cnt_nxt = cnt + 4'd1;
                        end
                    end else begin
                        state_nxt = HELD;
                        cnt_nxt   = 4'd0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        onehot_nxt = 16'd0;
        if (state_nxt == HELD || state_nxt == RELEASE) begin
            onehot_nxt = cand_nxt;
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner: stimulus queues expected key_valid /
// multi_err events, a negedge monitor pops and compares them as they appear.
module tb_hex_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key_onehot;
    logic        key_valid;
    logic        multi_err;
    logic [15:0] keys;

    typedef struct packed {
        logic        is_multi;
        logic [15:0] onehot;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .multi_err  (multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a row reads low when a pressed key sits on the driven column.
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[4*c + r] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    function automatic logic [3:0] encode(input logic [15:0] oh);
        logic [3:0] e;
        e = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) e = 4'(i);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (key_valid || multi_err)) begin
            n_cmp++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got valid=%0b multi_err=%0b onehot=%h, required no event",
                         key_valid, multi_err, key_onehot);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if ({key_valid, multi_err, key_onehot} !== {~e.is_multi, e.is_multi, e.onehot}) begin
                    n_bad++;
                    $display("FAIL event: got valid=%0b multi_err=%0b onehot=%h, required valid=%0b multi_err=%0b onehot=%h",
                             key_valid, multi_err, key_onehot, ~e.is_multi, e.is_multi, e.onehot);
                end
            end
        end
    end

    task automatic wait_drain(input string nm, input int budget);
        int i;
        i = 0;
        while (expq.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(nm, 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    // Returns at the negedge of the first cycle of a new frame (column 0, divider 0).
    task automatic align_frame();
        logic [3:0] prev;
        prev = col;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col == 4'b1110 && prev == 4'b0111) return;
            prev = col;
        end
        chk("align_timeout", 32'd1, 32'd0);
    endtask

    task automatic watch_onehot(input string nm, input int cycles, input logic [15:0] req);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (key_onehot !== req) bad++;
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    task automatic wait_onehot(input string nm, input int budget, input logic [15:0] req);
        int i;
        i = 0;
        while (key_onehot !== req && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(nm, {16'd0, key_onehot}, {16'd0, req});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ecol;
        rst_n = 1'b0;
        keys  = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", {9'd0, col, key_onehot, key_valid, multi_err},
            {9'd0, 4'b1110, 16'd0, 1'b0, 1'b0});

        // Column scan from the first cycle after reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ecol = 4'b0001 << ((i / 4) % 4);
            ecol = ~ecol;
            chk("col_scan", {28'd0, col}, {28'd0, ecol});
            chk("idle_outputs", {14'd0, key_onehot, key_valid, multi_err}, 32'd0);
            @(negedge clk);
        end

        // Clean press of key 9 (col 2, row 1).
        align_frame();
        keys = 16'h0200;
        expq.push_back('{is_multi: 1'b0, onehot: 16'h0200});
        wait_drain("press9_latency", 68);
        chk("press9_onehot", {16'd0, key_onehot}, 32'h0000_0200);
        chk("press9_encoder", {28'd0, encode(key_onehot)}, 32'd9);
        watch_onehot("press9_hold", 48, 16'h0200);

        // Release bounce: one zero frame, then re-press.
        align_frame();
        keys = 16'h0000;
        repeat (16) @(negedge clk);
        keys = 16'h0200;
        watch_onehot("release_bounce_hold", 64, 16'h0200);

        // Full release needs three zero frames.
        align_frame();
        keys = 16'h0000;
        repeat (30) @(negedge clk);
        chk("release_not_early", {16'd0, key_onehot}, 32'h0000_0200);
        wait_onehot("release_done", 40, 16'h0000);
        watch_onehot("idle_after_release", 32, 16'h0000);

        // Press bounce: key 5 for a single frame.
        align_frame();
        keys = 16'h0020;
        repeat (16) @(negedge clk);
        keys = 16'h0000;
        watch_onehot("press_bounce_onehot", 80, 16'h0000);

        // Keys 0 and 15 together for exactly four frames.
        align_frame();
        keys = 16'h8001;
        repeat (4) expq.push_back('{is_multi: 1'b1, onehot: 16'h0000});
        watch_onehot("multi_onehot", 64, 16'h0000);
        keys = 16'h0000;
        wait_drain("multi_count", 40);
        watch_onehot("multi_after", 32, 16'h0000);

        // Reset during the second confirming frame of key 15.
        align_frame();
        keys = 16'h8000;
        repeat (24) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midconfirm_reset", {9'd0, col, key_onehot, key_valid, multi_err},
            {9'd0, 4'b1110, 16'd0, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        chk("reset_held_outputs", {9'd0, col, key_onehot, key_valid, multi_err},
            {9'd0, 4'b1110, 16'd0, 1'b0, 1'b0});
        rst_n = 1'b1;
        expq.push_back('{is_multi: 1'b0, onehot: 16'h8000});
        wait_drain("press15_after_reset", 68);
        chk("press15_onehot", {16'd0, key_onehot}, 32'h0000_8000);
        chk("press15_encoder", {28'd0, encode(key_onehot)}, 32'd15);
        keys = 16'h0000;
        wait_onehot("release15", 80, 16'h0000);
        watch_onehot("final_idle", 40, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_keypad_scanner.md
HEX_KEYPAD_SCANNER -- requirements
Module: hex_keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clock cycles each column is driven. Legal range is 3..255.
REQ-002 SHALL have parameter DEBOUNCE, default 3: consecutive identical full-scan frames needed to accept a press or release. Legal range is 1..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port key_onehot  output  16  debounced key, one-hot; bit k = 4*c + r for column c, row r; all-zero means no key. It feeds the downstream 16-to-4 hex encoder directly.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a new debounced press is accepted.
REQ-009 SHALL have port multi_err  output  1  one-cycle pulse when a frame from IDLE shows more than one key.

Function
REQ-010 SHALL pass row through a 2-flop synchroniser before any use.
REQ-011 SHALL step col through 4'b1110, 1101, 1011, 0111 and wrap, holding each value for SCAN_DIV cycles.
REQ-012 SHALL sample the synchronised rows in the last cycle (SCAN_DIV-1) of each column window. Each row that reads 0 sets frame bit 4*c + r.
REQ-013 SHALL complete a frame at the column-3 sample, so one frame is 4*SCAN_DIV cycles. Frame evaluation SHALL occur in the next cycle.
REQ-014 SHALL implement the states IDLE, CONFIRM, HELD and RELEASE, with an internal candidate register cand[15:0] and a frame counter cnt.
REQ-015 In IDLE, the block SHALL react to the frame as follows:
  - single bit set -> CONFIRM, cand=frame, cnt=1;
  - all-zero -> stay;
  - more than one bit set -> stay, and pulse multi_err.
REQ-016 In CONFIRM, the block SHALL react to the frame as follows:
  - frame==cand -> cnt+1;
  - when cnt reaches DEBOUNCE -> HELD, key_onehot=cand, key_valid pulses for 1 cycle;
  - frame!=cand -> IDLE, cnt=0.
REQ-017 With DEBOUNCE=1, the block SHALL go from IDLE directly to HELD on the first single-key frame and pulse key_valid.
REQ-018 In HELD, the block SHALL react to the frame as follows:
  - frame==cand -> stay;
  - all-zero -> RELEASE, cnt=1 (or IDLE immediately if DEBOUNCE=1);
  - any other nonzero frame -> stay HELD, with no output change and no multi_err (rollover not supported).
REQ-019 In RELEASE, the block SHALL react to the frame as follows:
  - all-zero -> cnt+1;
  - when cnt reaches DEBOUNCE -> IDLE, key_onehot=0;
  - any nonzero frame -> HELD, with no key_valid.
REQ-020 SHALL hold key_onehot at cand throughout HELD and RELEASE, and at 0 in IDLE and CONFIRM.
REQ-021 SHALL never drive key_onehot with more than one bit set.
REQ-022 SHALL register key_valid and multi_err, and assert each for exactly one cycle per event.
REQ-023 Press latency SHALL be DEBOUNCE frames plus at most 1 frame plus 3 cycles, measured from row stable to key_valid.
REQ-024 Holding a key SHALL produce exactly one key_valid; a new key_valid requires passing through IDLE.

Reset
REQ-025 While rst_n=0, the block SHALL force these values asynchronously:
  - col=4'b1110;
  - key_onehot=0, key_valid=0, multi_err=0;
  - state IDLE, cand=0, cnt=0;
  - column and divider counters=0;
  - synchroniser flops=4'b1111.
REQ-026 After rst_n rises, scanning SHALL restart at column 0, cycle 0. No frame partially sampled before reset SHALL be used.
REQ-027 Reset asserted in any state SHALL discard any pending press, and SHALL produce no key_valid.

Verification (SCAN_DIV=4, DEBOUNCE=3, frame=16 cycles; bench models the keypad as row[r]=0 iff a pressed key at (c,r) has col[c]=0)
REQ-028 Bench SHALL cover column scan: after reset with no keys, col shows 1110,1101,1011,0111, each for 4 cycles, then wraps; all other outputs stay 0.
REQ-029 Bench SHALL cover a clean press: hold key 9 (col 2, row 1). Required response: exactly one key_valid pulse within 4 frames + 3 cycles; key_onehot=16'h0200 from that cycle; encoder output=4'h9.
REQ-030 Bench SHALL cover press bounce: key 5 present for 1 frame, then absent. Required response: no key_valid; key_onehot stays 16'h0000.
REQ-031 Bench SHALL cover release and release bounce, both with key 9 held:
  - release for 1 frame, then re-press -> key_onehot stays 16'h0200, no key_valid;
  - full release -> key_onehot=0 after 3 zero frames, no key_valid.
REQ-032 Bench SHALL cover a multi-key press: keys 0 and 15 pressed together from IDLE. Required response: multi_err pulses once per frame; no key_valid; key_onehot=0.
REQ-033 Bench SHALL cover reset mid-CONFIRM: pulse rst_n low during the second confirming frame of key 15. Required response: outputs take reset values immediately, no key_valid appears, and after release of rst_n a full press yields key_onehot=16'h8000.
